// File: rtl/bb_uart_rx.sv
// rtl/bb_uart_rx.sv - 8N1 UART receiver, 16x oversampled, ready/ack holding register
// with sticky framing and overrun flags.
module bb_uart_rx #(
  parameter int OVS  = 16,
  parameter int SAMP = 7
) (
  input  logic       bdclk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rxack,
  output logic [7:0] rxreg,
  output logic       rxrdy,
  output logic       rxbsy,
  output logic       rxferr,
  output logic       rxovr
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TMAX  = TW'(OVS - 1);
  localparam logic [TW-1:0] TSAMP = TW'(SAMP);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rxreg_n;
  logic          rxrdy_n, rxbsy_n, rxferr_n, rxovr_n;
  logic          s1, rs;

  always_ff @(posedge bdclk) begin
    if (!rstn) begin
      s1     <= 1'b1;
      rs     <= 1'b1;
      state  <= IDLE;
      tick   <= '0;
      bitn   <= '0;
      shift  <= '0;
      rxreg  <= '0;
      rxrdy  <= 1'b0;
      rxbsy  <= 1'b0;
      rxferr <= 1'b0;
      rxovr  <= 1'b0;
    end else begin
      s1     <= rxd;
      rs     <= s1;
      state  <= state_n;
      tick   <= tick_n;
      bitn   <= bitn_n;
      shift  <= shift_n;
      rxreg  <= rxreg_n;
      rxrdy  <= rxrdy_n;
      rxbsy  <= rxbsy_n;
      rxferr <= rxferr_n;
      rxovr  <= rxovr_n;
    end
  end

  // Acknowledge clears flags by default; a delivery or new error below overrides it.
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    bitn_n   = bitn;
    shift_n  = shift;
    rxreg_n  = rxreg;
    rxrdy_n  = rxrdy & ~rxack;
    rxbsy_n  = rxbsy;
    rxferr_n = rxferr & ~rxack;
    rxovr_n  = rxovr & ~rxack;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (!rs) begin
          state_n = START;
          rxbsy_n = 1'b1;
        end
      end
      START: begin
        if (tick == TSAMP) begin
          tick_n = '0;
          bitn_n = '0;
          if (!rs) begin
            state_n = DATA;
          end else begin
            state_n = IDLE;
            rxbsy_n = 1'b0;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DATA: begin
        if (tick == TMAX) begin
          tick_n  = '0;
          shift_n = {rs, shift[7:1]};
          if (bitn == 3'd7) state_n = STOP;
          else              bitn_n  = bitn + 1'b1;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      STOP: begin
        if (tick == TMAX) begin
          tick_n = '0;
          if (rs) begin
            state_n = IDLE;
            rxbsy_n = 1'b0;
            if (!rxrdy || rxack) begin
              rxreg_n = shift;
              rxrdy_n = 1'b1;
            end else begin
              rxovr_n = 1'b1;
            end
          end else begin
            rxferr_n = 1'b1;
            state_n  = BRK;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      BRK: begin
        tick_n = '0;
        if (rs) begin
          state_n = IDLE;
          rxbsy_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        rxbsy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bb_uart_rx.sv
// tb/tb_bb_uart_rx.sv - scoreboard bench for bb_uart_rx: directed frames, glitch,
// framing, overrun, ack collision, mid-frame reset and baud mismatch.
`timescale 1ns/1ps
module tb_bb_uart_rx;

  logic       bdclk = 1'b0;
  logic       rstn  = 1'b0;
  logic       rxd   = 1'b1;
  logic       rxack = 1'b0;
  logic [7:0] rxreg;
  logic       rxrdy, rxbsy, rxferr, rxovr;

  bb_uart_rx #(.OVS(16), .SAMP(7)) dut (
    .bdclk (bdclk),
    .rstn  (rstn),
    .rxd   (rxd),
    .rxack (rxack),
    .rxreg (rxreg),
    .rxrdy (rxrdy),
    .rxbsy (rxbsy),
    .rxferr(rxferr),
    .rxovr (rxovr)
  );

  always #5 bdclk = ~bdclk;

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   lax      = 1'b0;
  int   lax_events = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [7:0] d, input logic r, input logic f, input logic o);
    exp_t e;
    e.data = d; e.rdy = r; e.ferr = f; e.ovr = o;
    q.push_back(e);
  endtask

  // Monitor: any rising flag, or a new byte landing while rxrdy stays high, is a DUT event.
  initial begin
    logic [7:0] p_reg;
    logic p_rdy, p_ferr, p_ovr;
    exp_t e;
    p_reg = '0; p_rdy = 0; p_ferr = 0; p_ovr = 0;
    forever begin
      @(negedge bdclk);
      if (rstn && ((rxrdy && !p_rdy) || (rxferr && !p_ferr) || (rxovr && !p_ovr) ||
                   (rxrdy && p_rdy && rxreg != p_reg))) begin
        if (lax) begin
          lax_events++;
        end else if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          check("ev_rxreg",  int'(rxreg),  int'(e.data));
          check("ev_rxrdy",  int'(rxrdy),  int'(e.rdy));
          check("ev_rxferr", int'(rxferr), int'(e.ferr));
          check("ev_rxovr",  int'(rxovr),  int'(e.ovr));
        end
      end
      p_reg = rxreg; p_rdy = rxrdy; p_ferr = rxferr; p_ovr = rxovr;
    end
  end

  task automatic send_frame(input logic [7:0] d, input real cyc, input logic stopb);
    rxd = 1'b0;
    #(cyc * 10.0);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(cyc * 10.0);
    end
    rxd = stopb;
    #(cyc * 10.0);
    rxd = 1'b1;
  endtask

  task automatic align();
    @(posedge bdclk); #1;
  endtask

  task automatic ack();
    align(); rxack = 1'b1;
    align(); rxack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge bdclk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge bdclk); t++;
    end
    #1;
    check(name, q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rxreg"},  int'(rxreg),  0);
    check({tag, "_rxrdy"},  int'(rxrdy),  0);
    check({tag, "_rxbsy"},  int'(rxbsy),  0);
    check({tag, "_rxferr"}, int'(rxferr), 0);
    check({tag, "_rxovr"},  int'(rxovr),  0);
  endtask

  task automatic reset_mid_frame(input real cyc, input string tag);
    align();
    fork
      send_frame(8'hFF, cyc, 1'b1);
      begin
        #(cyc * 10.0 * 4.5);
        align(); rstn = 1'b0;
        align(); rstn = 1'b1;
        check_reset_vals(tag);
      end
    join
    idle(20);
    check_reset_vals({tag, "_after"});
  endtask

  initial begin
    int n, bsy_drop;
    bit saw_bsy;

    idle(3);
    rstn = 1'b1;
    idle(1);
    check_reset_vals("reset");

    // Nominal 0x55, latency and busy window
    expect_ev(8'h55, 1, 0, 0);
    align();
    n = 0; bsy_drop = 0;
    fork
      send_frame(8'h55, 16.0, 1'b1);
      begin
        while (n < 200) begin
          @(posedge bdclk); #1; n++;
          if (rxrdy) break;
          if (n >= 4 && !rxbsy) bsy_drop++;
        end
        check("lat_in_window", int'(n >= 153 && n <= 155), 1);
        check("bsy_throughout", bsy_drop, 0);
        check("bsy_low_after", int'(rxbsy), 0);
      end
    join
    wait_drain("drain_55");
    ack();
    idle(1);
    check("ack_clears_rdy", int'(rxrdy), 0);

    // Glitch then 0xA3
    align();
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    saw_bsy = 0;
    for (int i = 0; i < 14; i++) begin
      idle(1);
      if (rxbsy) saw_bsy = 1;
    end
    check("glitch_bsy_pulse", int'(saw_bsy), 1);
    check("glitch_bsy_low", int'(rxbsy), 0);
    check("glitch_no_rdy", int'(rxrdy), 0);
    expect_ev(8'hA3, 1, 0, 0);
    align(); send_frame(8'hA3, 16.0, 1'b1);
    idle(4);
    wait_drain("drain_a3");
    ack();

    // Framing error: stop bit low, line held low three more bit times
    expect_ev(8'hA3, 0, 1, 0);
    align(); send_frame(8'hA5, 16.0, 1'b0);
    rxd = 1'b0;
    #(3 * 160.0);
    check("brk_bsy_held", int'(rxbsy), 1);
    check("brk_ferr", int'(rxferr), 1);
    rxd = 1'b1;
    idle(6);
    check("brk_bsy_released", int'(rxbsy), 0);
    check("brk_rxreg_kept", int'(rxreg), 8'hA3);
    wait_drain("drain_ferr");
    ack();
    idle(1);
    check("ack_clears_ferr", int'(rxferr), 0);

    // Overrun
    expect_ev(8'h12, 1, 0, 0);
    expect_ev(8'h12, 1, 0, 1);
    align(); send_frame(8'h12, 16.0, 1'b1);
    send_frame(8'h34, 16.0, 1'b1);
    idle(4);
    wait_drain("drain_ovr");
    ack();
    idle(1);
    check("ack_clears_ovr", int'(rxovr), 0);
    check("ack_clears_rdy2", int'(rxrdy), 0);

    // Ack exactly on the stop-sample edge of 0x34 (2 sync + 1 detect + 8 + 128 + 16)
    expect_ev(8'h12, 1, 0, 0);
    expect_ev(8'h34, 1, 0, 0);
    align(); send_frame(8'h12, 16.0, 1'b1);
    idle(4);
    align();
    fork
      send_frame(8'h34, 16.0, 1'b1);
      begin
        repeat (154) @(posedge bdclk);
        #1 rxack = 1'b1;
        @(posedge bdclk);
        #1 rxack = 1'b0;
      end
    join
    idle(4);
    wait_drain("drain_coll");
    check("coll_rxreg", int'(rxreg), 8'h34);
    check("coll_rdy", int'(rxrdy), 1);
    check("coll_ovr", int'(rxovr), 0);
    ack();

    // Mid-frame reset, nominal rate
    reset_mid_frame(16.0, "rst16");
    expect_ev(8'h0F, 1, 0, 0);
    align(); send_frame(8'h0F, 16.0, 1'b1);
    idle(4);
    wait_drain("drain_0f_16");
    ack();

    // +6%: outside tolerance, only require that the frame terminates cleanly
    reset_mid_frame(17.0, "rst17");
    lax = 1'b1;
    align(); send_frame(8'h0F, 17.0, 1'b1);
    idle(40);
    lax = 1'b0;
    check("ovs17_frame_end", int'(lax_events != 0), 1);
    check("ovs17_idle", int'(rxbsy), 0);
    ack();
    idle(2);

    // -3%: must still receive correctly
    reset_mid_frame(15.5, "rst155");
    expect_ev(8'h0F, 1, 0, 0);
    align(); send_frame(8'h0F, 15.5, 1'b1);
    idle(4);
    wait_drain("drain_0f_155");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule

// File: doc/bb_uart_rx.md
Name: bb_uart_rx

Overview:
UART receiver for the ispMACH 4256ZE breakout board. It recovers 8N1 frames from the serial line driven by the PC (USB serial cable / MAX232), oversampling the line at 16x baud. It presents each received byte in a holding register with a ready/ack handshake toward the user logic, and flags framing and overrun errors. It is the receive-side partner of the board's UART transmitter and shares the same baud-clock source, run at 16x.

Parameters:
OVS, 16, bdclk cycles per bit; must be >= 4 and a power of two.
SAMP, 7, counter value inside the start bit at which the start bit is re-checked (mid-bit = OVS/2-1).

Ports:
bdclk  input  1  oversampling clock, OVS x baud (16 x 9600 = 153600 Hz for 9600 Bd); sole clock.
rstn  input  1  reset, synchronous, active-low, sampled on posedge bdclk.
rxd  input  1  serial line, asynchronous; idle 1.
rxack  input  1  consumer acknowledge; clears rxrdy/rxovr/rxferr.
rxreg  output  8  last good received byte.
rxrdy  output  1  rxreg holds an unacknowledged byte.
rxbsy  output  1  frame reception in progress.
rxferr  output  1  framing error (stop bit = 0), sticky.
rxovr  output  1  overrun, sticky.

Behaviour:
- Reset (rstn=0 at posedge bdclk): state IDLE, rxreg=8'h00, rxrdy=0, rxbsy=0, rxferr=0, rxovr=0, sync flops=1, counters=0. Reset mid-frame abandons the frame; nothing is delivered.
- rxd passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rs. There are 2 bdclk cycles of input latency.
- Counters: 4-bit tick counter (log2 OVS), 3-bit bit counter, 8-bit shift register.
- IDLE: rs=0 -> START, tick=0, rxbsy=1.
- START: tick increments each cycle. At tick==SAMP: rs=0 -> DATA, tick=0, bit=0. rs=1 -> glitch, back to IDLE, rxbsy=0, no flags set.
- DATA: at tick==OVS-1, sample rs, shift right into the MSB (LSB first), tick=0. After the 8th sample (bit==7) -> STOP; otherwise bit+1. Samples therefore land at mid-bit.
- STOP: at tick==OVS-1, sample rs:
  - rs=1 and (rxrdy=0 or rxack=1): rxreg<=shift, rxrdy<=1 -> IDLE, rxbsy=0.
  - rs=1 and rxrdy=1 and rxack=0: byte discarded, rxreg unchanged, rxovr<=1 -> IDLE.
  - rs=0: framing error. rxferr<=1, rxreg/rxrdy unchanged -> BREAK.
- BREAK: rxbsy stays 1. Wait for rs=1, then -> IDLE with rxbsy=0, so no false starts during a line break.
- Outputs are registered. rxrdy rises on the edge that takes the stop sample.
- rxack (level, sampled each posedge): clears rxrdy, rxovr and rxferr on the next edge. rxack with rxrdy=0 is harmless.
- Simultaneous rxack and good-stop delivery: delivery wins. The new byte loads, rxrdy stays 1, rxovr is not set, and stale flags are cleared.
- Simultaneous rxack and framing error: rxferr ends at 1.
- Counters wrap only by explicit reset to 0; tick never free-runs outside START/DATA/STOP.
- Tolerance: with the mid-bit sampling above, a baud mismatch up to about +/-3% must be received correctly.

Test Plan:
- Frame 0x55 at exactly 16 bdclk/bit, rxack=0 -> rxrdy=1, rxreg=8'h55, rxferr=0, rxovr=0. rxrdy rises 2+8+8*16+16 (=154) +/-1 cycles after the rxd falling edge. rxbsy is high throughout and low after.
- Glitch: rxd low for 4 bdclk, then high -> rxbsy pulses, returns to IDLE, rxrdy stays 0. A following 0xA3 frame is received correctly.
- Framing: 0xA5 with stop bit 0 and rxd held low 3 more bit times -> rxferr=1, rxrdy=0, rxreg unchanged. rxbsy stays 1 until rxd goes high. rxack then clears rxferr.
- Overrun: 0x12 then 0x34 back-to-back, no rxack -> rxreg=8'h12, rxrdy=1, rxovr=1. rxack clears both.
- Ack collision: send 0x12; assert rxack exactly on the 0x34 stop-sample edge -> rxreg=8'h34, rxrdy=1, rxovr=0.
- Reset mid-frame: rstn=0 for 1 cycle during bit 3 of 0xFF -> all outputs at reset values. The next 0x0F frame is received correctly. Repeat at 17 bdclk/bit (+6%) and 15.5 bdclk/bit (-3%). At -3%, 0x0F must still be received.
